// File: rtl/pipeline_pkg.sv
// Shared definitions for the keying-stage configuration controller:
// register addresses, blend mode encodings, parser states and reset defaults.
package pipeline_pkg;

   localparam logic [7:0] REG_CTRL    = 8'h00;
   localparam logic [7:0] REG_THRESH  = 8'h01;
   localparam logic [7:0] REG_OPACITY = 8'h02;
   localparam logic [7:0] REG_COMMIT  = 8'h0F;

   localparam logic [1:0] MODE_KEY   = 2'b00;
   localparam logic [1:0] MODE_BG    = 2'b01;
   localparam logic [1:0] MODE_FG    = 2'b10;
   localparam logic [1:0] MODE_BLEND = 2'b11;

   localparam logic [5:0] DEF_THRESH  = 6'b010000;
   localparam logic [3:0] DEF_OPACITY = 4'hF;
   localparam logic [1:0] DEF_MODE    = MODE_KEY;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GOT_ADDR,
      ST_GOT_HI,
      ST_APPLY
   } parser_state_t;

   // One full set of keying controls, used for both shadow and live copies.
   typedef struct packed {
      logic       en;
      logic [5:0] thresh;
      logic [1:0] mode;
      logic [3:0] opacity;
   } key_regs_t;

endpackage

// File: rtl/key_cmd_parser.sv
// Byte-stream command parser: collects ADDR, DATA_HI, DATA_LO and then
// presents a one-cycle write strobe with the assembled address and data.
//
// Handshake: a byte is transferred on every rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is low while cs_active is low and during
// the single APPLY cycle; it never depends on cmd_valid.
module key_cmd_parser
   import pipeline_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs_active,
   input  logic [7:0]    cmd_data,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   output logic          wr_en,
   output logic [7:0]    wr_addr,
   output logic [15:0]   wr_data,
   output parser_state_t state
);

   parser_state_t state_q;
   parser_state_t state_d;
   logic [7:0]    addr_q;
   logic [7:0]    hi_q;
   logic [7:0]    lo_q;
   logic          accept;

   assign accept = cmd_valid && cmd_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state: advance one step per accepted byte; chip-select loss aborts.
   always_comb begin
      state_d = state_q;
      if (!cs_active) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:     if (accept) state_d = ST_GOT_ADDR;
            ST_GOT_ADDR: if (accept) state_d = ST_GOT_HI;
            ST_GOT_HI:   if (accept) state_d = ST_APPLY;
            ST_APPLY:    state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs: ready except in APPLY or without chip select; strobe in APPLY.
   always_comb begin
      cmd_ready = cs_active && (state_q != ST_APPLY);
      wr_en     = (state_q == ST_APPLY);
   end

   // Byte capture into the field selected by the current state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= 8'h00;
         hi_q   <= 8'h00;
         lo_q   <= 8'h00;
      end else if (accept) begin
         case (state_q)
            ST_IDLE:     addr_q <= cmd_data;
            ST_GOT_ADDR: hi_q   <= cmd_data;
            ST_GOT_HI:   lo_q   <= cmd_data;
            default:     ;
         endcase
      end
   end

   assign wr_addr = addr_q;
   assign wr_data = {hi_q, lo_q};
   assign state   = state_q;

endmodule

// File: rtl/pipeline_key_config.sv
// Keying-stage configuration controller: decoded writes land in shadow
// registers, and a requested commit copies them to the live controls only
// on a frame_start, so keyer settings never change mid-frame.
module pipeline_key_config
   import pipeline_pkg::*;
#(
   parameter logic [5:0] DEFAULT_THRESH  = DEF_THRESH,
   parameter logic [3:0] DEFAULT_OPACITY = DEF_OPACITY,
   parameter logic [1:0] DEFAULT_MODE    = DEF_MODE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs_active,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       frame_start,
   output logic       key_enable,
   output logic [5:0] key_threshold,
   output logic [1:0] blend_mode,
   output logic [3:0] fg_opacity,
   output logic       commit_pending,
   output logic       commit_done,
   output logic       err_bad_addr
);

   localparam key_regs_t RESET_REGS = '{
      en:      1'b0,
      thresh:  DEFAULT_THRESH,
      mode:    DEFAULT_MODE,
      opacity: DEFAULT_OPACITY
   };

   logic          wr_en;
   logic [7:0]    wr_addr;
   logic [15:0]   wr_data;
   parser_state_t parser_state_unused;
   logic          unused_data_bits;

   key_regs_t shadow;
   key_regs_t live;
   logic      commit_load;
   logic      commit_set;
   logic      load_d;

   key_cmd_parser u_parser (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs_active (cs_active),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .state     (parser_state_unused)
   );

   // Data bits with no register behind them are deliberately ignored.
   assign unused_data_bits = ^wr_data[14:6];

   // A commit uses the pending flag as it stood before this cycle's APPLY.
   assign commit_load = frame_start && commit_pending;
   assign commit_set  = wr_en && (wr_addr == REG_COMMIT);

   // Shadow registers and the sticky bad-address flag, written in APPLY.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow       <= RESET_REGS;
         err_bad_addr <= 1'b0;
      end else if (wr_en) begin
         case (wr_addr)
            REG_CTRL: begin
               shadow.en   <= wr_data[0];
               shadow.mode <= wr_data[2:1];
               if (wr_data[15]) err_bad_addr <= 1'b0;
            end
            REG_THRESH:  shadow.thresh  <= wr_data[5:0];
            REG_OPACITY: shadow.opacity <= wr_data[3:0];
            REG_COMMIT:  ;
            default:     err_bad_addr   <= 1'b1;
         endcase
      end
   end

   // Pending flag: a new COMMIT wins over a clear, so it is never lost.
   always_ff @(posedge clk) begin
      if (!rst_n)           commit_pending <= 1'b0;
      else if (commit_set)  commit_pending <= 1'b1;
      else if (commit_load) commit_pending <= 1'b0;
   end

   // Live registers copy the pre-write shadow on a committing frame_start.
   always_ff @(posedge clk) begin
      if (!rst_n)           live <= RESET_REGS;
      else if (commit_load) live <= shadow;
   end

   // commit_done trails the live load by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_d      <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         load_d      <= commit_load;
         commit_done <= load_d;
      end
   end

   assign key_enable    = live.en;
   assign key_threshold = live.thresh;
   assign blend_mode    = live.mode;
   assign fg_opacity    = live.opacity;

endmodule

// File: tb/tb_pipeline_key_config.sv
// Self-checking bench for pipeline_key_config: directed scenarios followed by
// random command traffic, with a reference model of shadow/live/pending/error
// state and a scoreboard of expected live values checked at each commit_done.
module tb_pipeline_key_config;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs_active;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       frame_start;
   logic       key_enable;
   logic [5:0] key_threshold;
   logic [1:0] blend_mode;
   logic [3:0] fg_opacity;
   logic       commit_pending;
   logic       commit_done;
   logic       err_bad_addr;

   // Packed view of the live controls: {en, thresh[5:0], mode[1:0], opacity[3:0]}
   localparam logic [12:0] RESET_VAL = {1'b0, 6'h10, 2'b00, 4'hF};

   logic [12:0] exp_q[$];
   logic [12:0] m_shadow;
   logic [12:0] m_live;
   bit          m_pending;
   bit          m_err;
   logic [12:0] mon_exp;
   int          vectors    = 0;
   int          miscompares = 0;

   wire [12:0] live_now = {key_enable, key_threshold, blend_mode, fg_opacity};

   pipeline_key_config dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cs_active      (cs_active),
      .cmd_data       (cmd_data),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .frame_start    (frame_start),
      .key_enable     (key_enable),
      .key_threshold  (key_threshold),
      .blend_mode     (blend_mode),
      .fg_opacity     (fg_opacity),
      .commit_pending (commit_pending),
      .commit_done    (commit_done),
      .err_bad_addr   (err_bad_addr)
   );

   // Clock and reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model
   task automatic model_reset();
      m_shadow  = RESET_VAL;
      m_live    = RESET_VAL;
      m_pending = 0;
      m_err     = 0;
   endtask

   task automatic model_write(input logic [7:0] a, input logic [15:0] d);
      case (a)
         8'h00: begin
            m_shadow[12]  = d[0];
            m_shadow[5:4] = d[2:1];
            if (d[15]) m_err = 0;
         end
         8'h01: m_shadow[11:6] = d[5:0];
         8'h02: m_shadow[3:0]  = d[3:0];
         8'h0F: m_pending = 1;
         default: m_err = 1;
      endcase
   endtask

   task automatic model_frame();
      if (m_pending) begin
         exp_q.push_back(m_shadow);
         m_live    = m_shadow;
         m_pending = 0;
      end
   endtask

   // Driver tasks (inputs change 1 time unit after the rising edge)
   task automatic send_byte(input logic [7:0] b);
      bit ok = 0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
      if (!ok) check("byte_timeout", 0, 1);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] hi,
                             input logic [7:0] lo, input bit fs_on_apply);
      send_byte(a);
      send_byte(hi);
      send_byte(lo);
      // now in the APPLY cycle
      if (fs_on_apply) frame_start = 1'b1;
      @(negedge clk);
      check("ready_in_apply", cmd_ready, 0);
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      if (fs_on_apply) model_frame();
      model_write(a, {hi, lo});
      @(negedge clk);
      check("err_after_write", err_bad_addr, m_err);
      check("pending_after_write", commit_pending, m_pending);
      check("live_after_write", live_now, m_live);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame();
      bit          c   = m_pending;
      logic [12:0] old = m_live;
      frame_start = 1'b1;
      @(negedge clk);
      check("pending_at_fs", commit_pending, c);
      check("live_hold_at_fs", live_now, old);
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      model_frame();
      @(negedge clk);
      check("live_after_fs", live_now, m_live);
      check("pending_cleared", commit_pending, 0);
      check("done_early", commit_done, 0);
      @(negedge clk);
      check("done_pulse", commit_done, c);
      @(negedge clk);
      check("done_single", commit_done, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic abort_frame(input int n, input logic [7:0] b0, input logic [7:0] b1);
      send_byte(b0);
      if (n > 1) send_byte(b1);
      cs_active = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      check("ready_no_cs", cmd_ready, 0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cs_active = 1'b1;
   endtask

   task automatic check_defaults(input string tag);
      check({tag, "_thresh"},  key_threshold, 6'h10);
      check({tag, "_opacity"}, fg_opacity, 4'hF);
      check({tag, "_enable"},  key_enable, 0);
      check({tag, "_mode"},    blend_mode, 2'b00);
      check({tag, "_ready"},   cmd_ready, 1);
      check({tag, "_pending"}, commit_pending, 0);
      check({tag, "_done"},    commit_done, 0);
      check({tag, "_err"},     err_bad_addr, 0);
   endtask

   // Scoreboard monitor: every commit_done pops one expected live value
   always @(negedge clk) begin
      if (rst_n && commit_done) begin
         if (exp_q.size() == 0) begin
            check("done_unexpected", 1, 0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("commit_value", live_now, mon_exp);
         end
      end
   end

   // Stimulus
   initial begin
      logic [7:0] a;
      int         r;
      rst_n       = 1'b0;
      cs_active   = 1'b1;
      cmd_valid   = 1'b0;
      cmd_data    = 8'h00;
      frame_start = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_defaults("reset");
      @(posedge clk);
      #1;

      // threshold write then commit
      send_frame(8'h01, 8'h00, 8'h2A, 0);
      send_frame(8'h0F, 8'h00, 8'h00, 0);
      pulse_frame();
      check("thresh_2a", key_threshold, 6'h2A);

      // CTRL write without COMMIT leaves live untouched
      send_frame(8'h00, 8'h00, 8'h07, 0);
      pulse_frame();
      check("enable_unchanged", key_enable, 0);
      check("mode_unchanged", blend_mode, 2'b00);

      // aborted partial frame then opacity write
      abort_frame(2, 8'h01, 8'h00);
      send_frame(8'h02, 8'h00, 8'h05, 0);
      send_frame(8'h0F, 8'h00, 8'h00, 0);
      pulse_frame();
      check("opacity_5", fg_opacity, 4'h5);
      check("thresh_kept", key_threshold, 6'h2A);

      // COMMIT APPLY coincident with frame_start
      send_frame(8'h01, 8'h00, 8'h3F, 0);
      send_frame(8'h0F, 8'h00, 8'h00, 1);
      check("coincide_pending", commit_pending, 1);
      pulse_frame();
      check("coincide_applied", key_threshold, 6'h3F);

      // shadow write coincident with a committing frame_start
      send_frame(8'h0F, 8'h00, 8'h00, 0);
      send_frame(8'h01, 8'h00, 8'h01, 1);
      check("prewrite_live", key_threshold, 6'h3F);

      // bad address, then clear via CTRL bit15
      send_frame(8'h33, 8'h12, 8'h34, 0);
      check("bad_addr_set", err_bad_addr, 1);
      send_frame(8'h00, 8'h80, 8'h00, 0);
      check("bad_addr_clr", err_bad_addr, 0);
      send_frame(8'h0F, 8'h00, 8'h00, 0);
      pulse_frame();
      check("ctrl_enable_0", key_enable, 0);

      // random traffic
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         case ($urandom_range(0, 4))
            0: a = 8'h00;
            1: a = 8'h01;
            2: a = 8'h02;
            3: a = 8'h0F;
            default: a = 8'($urandom);
         endcase
         if (r <= 5)      send_frame(a, 8'($urandom), 8'($urandom), 0);
         else if (r <= 7) pulse_frame();
         else if (r == 8) abort_frame($urandom_range(1, 2), a, 8'($urandom));
         else             send_frame(a, 8'($urandom), 8'($urandom), 1);
      end
      repeat (3) @(posedge clk);
      #1;

      // reset mid-transaction with a commit pending
      send_frame(8'h01, 8'h00, 8'h22, 0);
      send_frame(8'h0F, 8'h00, 8'h00, 0);
      send_byte(8'h02);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      check_defaults("midreset");
      @(posedge clk);
      #1;
      pulse_frame();
      check("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
